jzjpcc_sram_lsu: RTL and testbench

Initiator side of the word-wide inferred SRAM port: a load/store unit that takes single RISC-V memory requests from the pipeline's memory stage and drives one SRAM port (address, write data, write enable; registered one-cycle read). Performs byte-lane extraction and sign/zero extension for loads. Performs read-modify-write for sub-word stores, since the SRAM port writes only whole 32-bit words. Sits between the memory stage and the data-side port of the dual-port inferred SRAM.

---
 rtl/jzjpcc_lsu_pkg.sv | 20 ++
 rtl/jzjpcc_lsu_align.sv | 32 +++
 rtl/jzjpcc_sram_lsu.sv | 122 ++++++++++++
 tb/tb_jzjpcc_sram_lsu.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jzjpcc_lsu_pkg.sv
// jzjpcc_lsu_pkg: state encoding, funct3 codes and request legality for the SRAM load/store unit
package jzjpcc_lsu_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, MERGE = 2'd2} lsu_state_t;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    // Unsigned variants exist only for loads; halves need even, words need word-aligned addresses.
    function automatic logic isLegal(input logic write, input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3)
            F3_B:    isLegal = 1'b1;
            F3_H:    isLegal = !addr[0];
            F3_W:    isLegal = addr == 2'b00;
            F3_BU:   isLegal = !write;
            F3_HU:   isLegal = !write && !addr[0];
            default: isLegal = 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/jzjpcc_lsu_align.sv
// jzjpcc_lsu_align: byte-lane extraction/extension for loads and lane merge for sub-word stores
module jzjpcc_lsu_align
    import jzjpcc_lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] data_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [4:0]  shamt_b;
    logic [4:0]  shamt_h;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    always_comb begin
        shamt_b   = {offset_i, 3'b000};
        shamt_h   = {offset_i[1], 4'b0000};
        byte_sel  = 8'(word_i >> shamt_b);
        half_sel  = 16'(word_i >> shamt_h);
        load_o    = funct3_i == F3_B  ? {{24{byte_sel[7]}}, byte_sel} :
                    funct3_i == F3_BU ? {24'd0, byte_sel} :
                    funct3_i == F3_H  ? {{16{half_sel[15]}}, half_sel} :
                    funct3_i == F3_HU ? {16'd0, half_sel} : word_i;
        lane_mask = funct3_i[1:0] == 2'b00 ? 32'h0000_00FF << shamt_b :
                    funct3_i[1:0] == 2'b01 ? 32'h0000_FFFF << shamt_h : 32'hFFFF_FFFF;
        lane_data = funct3_i[1:0] == 2'b01 ? data_i << shamt_h : data_i << shamt_b;
        merge_o   = (word_i & ~lane_mask) | (lane_data & lane_mask);
    end
endmodule

// File: rtl/jzjpcc_sram_lsu.sv
// jzjpcc_sram_lsu: load/store unit driving one word-wide SRAM port, with read-modify-write for SB/SH
module jzjpcc_sram_lsu
    import jzjpcc_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [2:0]            reqFunct3,
    input  logic [31:0]           reqAddress,
    input  logic [31:0]           reqWriteData,
    output logic                  respValid,
    output logic [31:0]           respReadData,
    output logic                  respError,
    output logic [ADDR_WIDTH-1:0] sramAddress,
    output logic [31:0]           sramWriteData,
    output logic                  sramWriteEnable,
    input  logic [31:0]           sramReadData
);
    lsu_state_t            state_q, state_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;
    logic [31:0]           data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_error_q, resp_error_d;
    logic [31:0]           resp_data_q, resp_data_d;
    logic [ADDR_WIDTH-1:0] req_word_addr;
    logic                  accept;
    logic                  legal;
    logic                  is_sw;
    logic [31:0]           load_value;
    logic [31:0]           merged_word;
    logic                  unused_addr;

    assign req_word_addr = reqAddress[ADDR_WIDTH+1:2];
    assign unused_addr   = ^reqAddress[31:ADDR_WIDTH+2];
    assign accept        = reqValid && state_q == IDLE;
    assign legal         = isLegal(reqWrite, reqFunct3, reqAddress[1:0]);
    assign is_sw         = reqWrite && reqFunct3 == F3_W;

    jzjpcc_lsu_align u_align (
        .word_i   (sramReadData),
        .data_i   (data_q),
        .funct3_i (f3_q),
        .offset_i (off_q),
        .load_o   (load_value),
        .merge_o  (merged_word)
    );

    always_comb begin
        state_d      = state_q;
        f3_d         = f3_q;
        off_d        = off_q;
        data_d       = data_q;
        addr_d       = addr_q;
        resp_valid_d = 1'b0;
        resp_error_d = resp_error_q;
        resp_data_d  = resp_data_q;
        case (state_q)
            IDLE: if (accept) begin
                f3_d   = reqFunct3;
                off_d  = reqAddress[1:0];
                data_d = reqWriteData;
                addr_d = req_word_addr;
                if (!legal || is_sw) begin
                    resp_valid_d = 1'b1;
                    resp_error_d = !legal;
                    resp_data_d  = '0;
                end else begin
                    state_d = reqWrite ? MERGE : LOAD;
                end
            end
            LOAD: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                resp_data_d  = load_value;
            end
            MERGE: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                resp_data_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset suppresses the strobe combinationally so an aborted merge never reaches the array.
    always_comb begin
        reqReady        = state_q == IDLE;
        sramAddress     = state_q == IDLE ? req_word_addr : addr_q;
        sramWriteData   = state_q == MERGE ? merged_word : reqWriteData;
        sramWriteEnable = !reset && (state_q == MERGE || (accept && legal && is_sw));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign respValid    = resp_valid_q;
    assign respError    = resp_error_q;
    assign respReadData = resp_data_q;
endmodule

// File: tb/tb_jzjpcc_sram_lsu.sv
// tb_jzjpcc_sram_lsu: scoreboard bench with a byte-addressed memory model and an inferred-SRAM stand-in
module tb_jzjpcc_sram_lsu;
    localparam int AW = 14;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          reqValid = 1'b0;
    logic          reqWrite = 1'b0;
    logic [2:0]    reqFunct3 = 3'd0;
    logic [31:0]   reqAddress = 32'd0;
    logic [31:0]   reqWriteData = 32'd0;
    logic          reqReady;
    logic          respValid;
    logic [31:0]   respReadData;
    logic          respError;
    logic [AW-1:0] sramAddress;
    logic [31:0]   sramWriteData;
    logic          sramWriteEnable;
    logic [31:0]   sramReadData;

    jzjpcc_sram_lsu #(.ADDR_WIDTH(AW)) dut (
        .clock           (clock),
        .reset           (reset),
        .reqValid        (reqValid),
        .reqReady        (reqReady),
        .reqWrite        (reqWrite),
        .reqFunct3       (reqFunct3),
        .reqAddress      (reqAddress),
        .reqWriteData    (reqWriteData),
        .respValid       (respValid),
        .respReadData    (respReadData),
        .respError       (respError),
        .sramAddress     (sramAddress),
        .sramWriteData   (sramWriteData),
        .sramWriteEnable (sramWriteEnable),
        .sramReadData    (sramReadData)
    );

    always #5 clock = ~clock;

    typedef struct {int cyc; logic err; logic [31:0] data;} resp_t;
    typedef struct {int cyc; logic [AW-1:0] addr; logic [31:0] data;} wr_t;

    resp_t       rq[$];
    wr_t         wq[$];
    resp_t       re;
    wr_t         we_e;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_data = 32'd0;
    logic        last_err = 1'b0;
    logic [7:0]  rb [0:65535];
    logic [31:0] mem [0:(1<<AW)-1];

    function automatic logic [31:0] seed_word(input int w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Stand-in for the SRAM data port: read-first, one-cycle registered read.
    always @(posedge clock) begin
        if (cyc == 0) begin
            for (int w = 0; w < (1 << AW); w++) mem[w] <= seed_word(w);
        end else if (sramWriteEnable) begin
            mem[sramAddress] <= sramWriteData;
        end
        sramReadData <= mem[sramAddress];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && respValid) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got respValid=1 expected none (cycle %0d)", cyc);
            end else begin
                re = rq.pop_front();
                check("resp_cycle", cyc, re.cyc);
                check("resp_error", {31'd0, respError}, {31'd0, re.err});
                check("resp_data", respReadData, re.data);
            end
            last_data = respReadData;
            last_err  = respError;
        end
        if (sramWriteEnable) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got write addr %h data %h expected none (cycle %0d)", sramAddress, sramWriteData, cyc);
            end else begin
                we_e = wq.pop_front();
                check("write_cycle", cyc, we_e.cyc);
                check("write_addr", 32'(sramAddress), 32'(we_e.addr));
                check("write_data", sramWriteData, we_e.data);
            end
        end
    end

    // Reference: byte-addressed memory, access size from funct3, natural-alignment rule.
    task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data, input int acc);
        int size;
        int base;
        int wb;
        bit legal;
        logic [31:0] v;
        size  = 1 << f3[1:0];
        base  = int'(addr[15:0]);
        wb    = base & ~3;
        legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || (!wr && (f3 == 3'd4 || f3 == 3'd5))) && (base % size == 0);
        if (!legal) begin
            rq.push_back('{acc + 1, 1'b1, 32'd0});
        end else if (wr) begin
            for (int k = 0; k < size; k++) rb[base + k] = 8'(data >> (8 * k));
            v = {rb[wb + 3], rb[wb + 2], rb[wb + 1], rb[wb]};
            wq.push_back('{size == 4 ? acc : acc + 1, AW'(wb / 4), v});
            rq.push_back('{size == 4 ? acc + 1 : acc + 2, 1'b0, 32'd0});
        end else begin
            v = 32'd0;
            for (int k = 0; k < size; k++) v = v | (32'(rb[base + k]) << (8 * k));
            if (!f3[2] && size < 4 && v[8 * size - 1]) v = v - (32'd1 << (8 * size));
            rq.push_back('{acc + 2, 1'b0, v});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the acceptance cycle.
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data, input bit track, output int acc);
        int waited;
        reqValid     = 1'b1;
        reqWrite     = wr;
        reqFunct3    = f3;
        reqAddress   = addr;
        reqWriteData = data;
        waited       = 0;
        #2;
        while (!reqReady && waited < 20) begin
            @(posedge clock);
            #3;
            waited++;
        end
        if (!reqReady) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got reqReady=0 expected 1 within 20 cycles");
            acc = -1;
        end else begin
            acc = cyc;
            if (track) model(wr, f3, addr, data, acc);
        end
        @(posedge clock);
        #1;
        reqValid = 1'b0;
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (rq.size() != 0 || wq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got %0d pending responses expected 0", rq.size());
            rq.delete();
            wq.delete();
        end
    endtask

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic op_check(input string name, input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                            input logic exp_err, input logic [31:0] exp_data);
        int acc;
        issue(wr, f3, addr, data, 1'b1, acc);
        wait_resp();
        check({name, "_err"}, {31'd0, last_err}, {31'd0, exp_err});
        check({name, "_data"}, last_data, exp_data);
        sync();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int a2;
        logic [31:0] r;
        logic [31:0] addr;
        for (int w = 0; w < (1 << AW); w++) begin
            r = seed_word(w);
            for (int k = 0; k < 4; k++) rb[w * 4 + k] = 8'(r >> (8 * k));
        end
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #3;
        check("reset_ready", {31'd0, reqReady}, 32'd1);
        check("reset_resp_valid", {31'd0, respValid}, 32'd0);
        check("reset_resp_error", {31'd0, respError}, 32'd0);
        check("reset_resp_data", respReadData, 32'd0);
        check("reset_write_enable", {31'd0, sramWriteEnable}, 32'd0);
        sync();

        op_check("sw_basic", 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'd0);
        op_check("sw_lanes", 1'b1, 3'b010, 32'h0000_0010, 32'h80F0_7F01, 1'b0, 32'd0);
        op_check("lb", 1'b0, 3'b000, 32'h0000_0013, 32'd0, 1'b0, 32'hFFFF_FF80);
        op_check("lbu", 1'b0, 3'b100, 32'h0000_0013, 32'd0, 1'b0, 32'h0000_0080);
        op_check("lh", 1'b0, 3'b001, 32'h0000_0012, 32'd0, 1'b0, 32'hFFFF_80F0);
        op_check("lhu", 1'b0, 3'b101, 32'h0000_0012, 32'd0, 1'b0, 32'h0000_80F0);
        op_check("lb_pos", 1'b0, 3'b000, 32'h0000_0011, 32'd0, 1'b0, 32'h0000_007F);

        op_check("sw_rmw", 1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344, 1'b0, 32'd0);
        op_check("sb_rmw", 1'b1, 3'b000, 32'h0000_0011, 32'h5566_77AA, 1'b0, 32'd0);
        op_check("lw_after_sb", 1'b0, 3'b010, 32'h0000_0010, 32'd0, 1'b0, 32'h1122_AA44);
        op_check("sh_rmw", 1'b1, 3'b001, 32'hABCD_0012, 32'h0000_BEEF, 1'b0, 32'd0);
        op_check("lw_after_sh", 1'b0, 3'b010, 32'h0000_0010, 32'd0, 1'b0, 32'hBEEF_AA44);

        op_check("lw_misaligned", 1'b0, 3'b010, 32'h0000_0002, 32'd0, 1'b1, 32'd0);
        op_check("sh_misaligned", 1'b1, 3'b001, 32'h0000_0005, 32'h0000_1234, 1'b1, 32'd0);
        op_check("load_f3_011", 1'b0, 3'b011, 32'h0000_0000, 32'd0, 1'b1, 32'd0);
        op_check("sbu_illegal", 1'b1, 3'b100, 32'h0000_0000, 32'd0, 1'b1, 32'd0);
        op_check("ok_after_error", 1'b0, 3'b010, 32'h0000_0010, 32'd0, 1'b0, 32'hBEEF_AA44);

        issue(1'b1, 3'b000, 32'h0000_0020, 32'h0000_00CC, 1'b0, a1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #3;
        check("ready_after_reset", {31'd0, reqReady}, 32'd1);
        repeat (3) @(negedge clock);
        #1;
        sync();
        op_check("lw_after_abort", 1'b0, 3'b010, 32'h0000_0020, 32'd0, 1'b0, {rb[35], rb[34], rb[33], rb[32]});

        issue(1'b0, 3'b010, 32'h0000_0010, 32'd0, 1'b1, a1);
        issue(1'b0, 3'b001, 32'h0000_0012, 32'd0, 1'b1, a2);
        check("held_load_spacing", a2 - a1, 32'd2);
        wait_resp();
        sync();
        issue(1'b1, 3'b010, 32'h0000_0030, 32'h0102_0304, 1'b1, a1);
        issue(1'b1, 3'b010, 32'h0000_0034, 32'h0506_0708, 1'b1, a2);
        check("sw_back_to_back", a2 - a1, 32'd1);
        wait_resp();
        sync();

        for (int i = 0; i < 400; i++) begin
            r    = $urandom;
            addr = {r[31:16], 10'd0, r[5:0]};
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom, 1'b1, a1);
            repeat ($urandom_range(0, 2)) sync();
        end
        wait_resp();
        check("resp_queue_empty", rq.size(), 32'd0);
        check("write_queue_empty", wq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
